// File: rtl/life_engine_core.sv
// Game-of-Life compute core: two ping-pong cell banks, STEP/CLEAR/RANDOM/NOP commands,
// a registered display read port, host cell writes and running board statistics.
module life_engine_core #(
  parameter int LOG_W = 5,
  parameter int LOG_H = 4,
  parameter int WRAP  = 1,
  parameter int GEN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [8:0]             birth_mask,
  input  logic [8:0]             survive_mask,
  input  logic                   rand_bit,
  input  logic                   wr_en,
  input  logic [LOG_W+LOG_H-1:0] wr_addr,
  input  logic                   wr_data,
  input  logic [LOG_W+LOG_H-1:0] rd_addr,
  output logic                   rd_data,
  output logic                   busy,
  output logic                   done,
  output logic [GEN_W-1:0]       gen_count,
  output logic [LOG_W+LOG_H:0]   population,
  output logic                   changed,
  output logic                   extinct
);
  localparam int A  = LOG_W + LOG_H;
  localparam int N  = 1 << A;
  localparam int PW = A + 1;

  localparam logic [1:0] OP_STEP   = 2'd0;
  localparam logic [1:0] OP_CLEAR  = 2'd1;
  localparam logic [1:0] OP_RANDOM = 2'd2;

  // Neighbour visiting order for scan phases 0..7
  localparam int DX [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
  localparam int DY [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FILL, S_FINISH} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       op_reg;
  logic [8:0]       birth_reg, survive_reg;
  logic             bank_sel_reg;
  logic [A-1:0]     idx_reg, idx_next;
  logic [3:0]       phase_reg, phase_next;
  logic [3:0]       acc_reg, acc_next;
  logic [PW-1:0]    pop_acc_reg, pop_acc_next;
  logic             chg_acc_reg, chg_acc_next;
  logic [GEN_W-1:0] gen_reg;
  logic [PW-1:0]    pop_reg;
  logic             changed_reg, done_reg, rd_data_reg;

  // Both banks live in one array indexed {bank, y, x}
  logic cells [2*N];

  logic         mem_we, mem_wbank, mem_wdata;
  logic [A-1:0] mem_waddr;
  logic         accept, host_wr, wr_old, new_cell;
  logic         nb_q, nb_valid_q, ctr_q;
  logic [3:0]   nsum;

  logic [LOG_W-1:0] cx;
  logic [LOG_H-1:0] cy;
  logic [A-1:0]     nb_addr [8];
  logic [7:0]       nb_ok;

  assign cx = idx_reg[LOG_W-1:0];
  assign cy = idx_reg[A-1:LOG_W];

  for (genvar gi = 0; gi < 8; gi++) begin : g_nb
    logic [LOG_W-1:0] nx;
    logic [LOG_H-1:0] ny;
    logic             ok_x, ok_y;

    always_comb begin
      nx   = cx + LOG_W'(DX[gi]);
      ny   = cy + LOG_H'(DY[gi]);
      ok_x = 1'b1;
      ok_y = 1'b1;
      if (DX[gi] < 0 && cx == '0) ok_x = 1'b0;
      if (DX[gi] > 0 && cx == '1) ok_x = 1'b0;
      if (DY[gi] < 0 && cy == '0) ok_y = 1'b0;
      if (DY[gi] > 0 && cy == '1) ok_y = 1'b0;
    end

    // Power-of-two board: the truncated sum already wraps, so only the
    // bounded mode needs the edge flags.
    assign nb_addr[gi] = {ny, nx};
    assign nb_ok[gi]   = (WRAP != 0) || (ok_x && ok_y);
  end

  // Phase 8 sees the phase-7 read still sitting in nb_q
  assign nsum = acc_reg + {3'b000, nb_q & nb_valid_q};

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    phase_next   = phase_reg;
    acc_next     = acc_reg;
    pop_acc_next = pop_acc_reg;
    chg_acc_next = chg_acc_reg;
    mem_we       = 1'b0;
    mem_wbank    = bank_sel_reg;
    mem_waddr    = wr_addr;
    mem_wdata    = wr_data;
    accept       = 1'b0;
    host_wr      = 1'b0;
    new_cell     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (wr_en) begin
          mem_we  = 1'b1;
          host_wr = 1'b1;
        end
        if (cmd_valid) begin
          accept       = 1'b1;
          idx_next     = '0;
          phase_next   = '0;
          acc_next     = '0;
          pop_acc_next = '0;
          chg_acc_next = 1'b0;
          case (cmd_op)
            OP_STEP:             state_next = S_SCAN;
            OP_CLEAR, OP_RANDOM: state_next = S_FILL;
            default:             state_next = S_FINISH;
          endcase
        end
      end
      S_SCAN: begin
        if (phase_reg == 4'd8) begin
          new_cell     = ctr_q ? survive_reg[nsum] : birth_reg[nsum];
          mem_we       = 1'b1;
          mem_wbank    = ~bank_sel_reg;
          mem_waddr    = idx_reg;
          mem_wdata    = new_cell;
          pop_acc_next = pop_acc_reg + PW'(new_cell);
          chg_acc_next = chg_acc_reg | (new_cell ^ ctr_q);
          phase_next   = '0;
          acc_next     = '0;
          if (idx_reg == '1) state_next = S_FINISH;
          else               idx_next   = idx_reg + A'(1);
        end else begin
          if (phase_reg != 4'd0) acc_next = nsum;
          phase_next = phase_reg + 4'd1;
        end
      end
      S_FILL: begin
        mem_we       = 1'b1;
        mem_waddr    = idx_reg;
        mem_wdata    = (op_reg == OP_RANDOM) & rand_bit;
        pop_acc_next = pop_acc_reg + PW'(mem_wdata);
        if (idx_reg == '1) state_next = S_FINISH;
        else               idx_next   = idx_reg + A'(1);
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Cell storage: one write port, registered scan reads
  always_ff @(posedge clk) begin
    if (mem_we) cells[{mem_wbank, mem_waddr}] <= mem_wdata;
    nb_q       <= cells[{bank_sel_reg, nb_addr[phase_reg[2:0]]}];
    nb_valid_q <= nb_ok[phase_reg[2:0]];
    ctr_q      <= cells[{bank_sel_reg, idx_reg}];
  end

  // Old value under the host write, needed for the incremental population update
  assign wr_old = cells[{bank_sel_reg, wr_addr}];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      op_reg       <= OP_STEP;
      birth_reg    <= '0;
      survive_reg  <= '0;
      bank_sel_reg <= 1'b0;
      idx_reg      <= '0;
      phase_reg    <= '0;
      acc_reg      <= '0;
      pop_acc_reg  <= '0;
      chg_acc_reg  <= 1'b0;
      gen_reg      <= '0;
      pop_reg      <= '0;
      changed_reg  <= 1'b0;
      done_reg     <= 1'b0;
      rd_data_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      phase_reg   <= phase_next;
      acc_reg     <= acc_next;
      pop_acc_reg <= pop_acc_next;
      chg_acc_reg <= chg_acc_next;
      rd_data_reg <= cells[{bank_sel_reg, rd_addr}];
      done_reg    <= 1'b0;
      if (accept) begin
        op_reg      <= cmd_op;
        birth_reg   <= birth_mask;
        survive_reg <= survive_mask;
      end
      if (host_wr) begin
        if (wr_data && !wr_old)      pop_reg <= pop_reg + PW'(1);
        else if (!wr_data && wr_old) pop_reg <= pop_reg - PW'(1);
      end
      if (state_reg == S_FINISH) begin
        done_reg <= 1'b1;
        case (op_reg)
          OP_STEP: begin
            bank_sel_reg <= ~bank_sel_reg;
            gen_reg      <= gen_reg + GEN_W'(1);
            pop_reg      <= pop_acc_reg;
            changed_reg  <= chg_acc_reg;
          end
          OP_CLEAR, OP_RANDOM: begin
            gen_reg     <= '0;
            pop_reg     <= pop_acc_reg;
            changed_reg <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd_ready  = (state_reg == S_IDLE);
  assign busy       = (state_reg != S_IDLE);
  assign done       = done_reg;
  assign gen_count  = gen_reg;
  assign population = pop_reg;
  assign changed    = changed_reg;
  assign extinct    = (pop_reg == '0);
  assign rd_data    = rd_data_reg;

endmodule

// File: tb/tb_life_engine_core.sv
// Bench for life_engine_core: one toroidal and one bounded instance share stimulus and
// are compared against an array-based Life model, plus table-driven host-write vectors.
module tb_life_engine_core;
  localparam int LW = 5;
  localparam int LH = 4;
  localparam int W  = 32;
  localparam int H  = 16;
  localparam int N  = W * H;
  localparam int A  = LW + LH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd_op = 2'd3;
  logic [8:0]   birth_mask = '0, survive_mask = '0;
  logic         rand_bit = 1'b0;
  logic         wr_en = 1'b0;
  logic [A-1:0] wr_addr = '0, rd_addr = '0;
  logic         wr_data = 1'b0;

  logic         ready1, rd1, busy1, done1, chg1, ext1;
  logic [15:0]  gen1;
  logic [A:0]   pop1;
  logic         ready0, rd0, busy0, done0, chg0, ext0;
  logic [15:0]  gen0;
  logic [A:0]   pop0;

  always #5 clk = ~clk;

  life_engine_core #(.LOG_W(LW), .LOG_H(LH), .WRAP(1), .GEN_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready1), .cmd_op(cmd_op),
    .birth_mask(birth_mask), .survive_mask(survive_mask), .rand_bit(rand_bit),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd1),
    .busy(busy1), .done(done1), .gen_count(gen1), .population(pop1), .changed(chg1),
    .extinct(ext1));

  life_engine_core #(.LOG_W(LW), .LOG_H(LH), .WRAP(0), .GEN_W(16)) u_dut_nowrap (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready0), .cmd_op(cmd_op),
    .birth_mask(birth_mask), .survive_mask(survive_mask), .rand_bit(rand_bit),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd0),
    .busy(busy0), .done(done0), .gen_count(gen0), .population(pop0), .changed(chg0),
    .extinct(ext0));

  int checks = 0;
  int errors = 0;

  // Model boards: index 0 = toroidal instance, 1 = bounded instance
  bit mb [2][N];
  bit exp_chg [2];
  int exp_gen = 0;
  bit rq [$];

  typedef struct {
    int x;
    int y;
    bit d;
    int pop;
  } wr_vec_t;
  wr_vec_t wv [8];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int mpop(input int k);
    int p = 0;
    for (int i = 0; i < N; i++) p += int'(mb[k][i]);
    return p;
  endfunction

  function automatic int at(input int x, input int y);
    return y * W + x;
  endfunction

  task automatic model_step(input logic [8:0] bm, input logic [8:0] sm);
    bit nb [N];
    for (int k = 0; k < 2; k++) begin
      exp_chg[k] = 1'b0;
      for (int y = 0; y < H; y++) begin
        for (int x = 0; x < W; x++) begin
          int n;
          n = 0;
          for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
              int xx, yy;
              xx = x + dx;
              yy = y + dy;
              if (dx != 0 || dy != 0) begin
                if (k == 0) begin
                  xx = (xx + W) % W;
                  yy = (yy + H) % H;
                  n += int'(mb[k][yy * W + xx]);
                end else if (xx >= 0 && xx < W && yy >= 0 && yy < H) begin
                  n += int'(mb[k][yy * W + xx]);
                end
              end
            end
          end
          nb[y * W + x] = mb[k][y * W + x] ? sm[n] : bm[n];
          if (nb[y * W + x] != mb[k][y * W + x]) exp_chg[k] = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) mb[k][i] = nb[i];
    end
    exp_gen = (exp_gen + 1) % 65536;
  endtask

  task automatic model_fill(input bit rnd);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) mb[k][i] = rnd ? rq[i] : 1'b0;
      exp_chg[k] = 1'b0;
    end
    exp_gen = 0;
  endtask

  task automatic check_stats(input string tag);
    check({tag, " pop wrap"},     pop1, mpop(0));
    check({tag, " pop nowrap"},   pop0, mpop(1));
    check({tag, " gen wrap"},     gen1, exp_gen);
    check({tag, " gen nowrap"},   gen0, exp_gen);
    check({tag, " chg wrap"},     chg1, exp_chg[0]);
    check({tag, " chg nowrap"},   chg0, exp_chg[1]);
    check({tag, " ext wrap"},     ext1, mpop(0) == 0);
    check({tag, " ext nowrap"},   ext0, mpop(1) == 0);
  endtask

  task automatic check_board(input string tag);
    int bad1, bad0;
    bad1 = 0;
    bad0 = 0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      rd_addr = A'(i);
      @(negedge clk);
      if (rd1 != mb[0][i]) bad1++;
      if (rd0 != mb[1][i]) bad0++;
    end
    check({tag, " board wrap bad cells"}, bad1, 0);
    check({tag, " board nowrap bad cells"}, bad0, 0);
    $display("board %s: read %0d cells, pop %0d/%0d", tag, N, mpop(0), mpop(1));
  endtask

  task automatic host_write(input int x, input int y, input bit d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = A'(at(x, y));
    wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
    mb[0][at(x, y)] = d;
    mb[1][at(x, y)] = d;
  endtask

  // Issues one command; cyc = cycles from accept edge to the cycle done is seen.
  task automatic do_cmd(input logic [1:0] op, input logic [8:0] bm, input logic [8:0] sm,
                        input bit hold, input bit poke, input bit cw, input int cw_addr,
                        input bit cw_data, output int cyc, output int idle_seen);
    bit rb;
    @(negedge clk);
    cmd_op = op;
    birth_mask = bm;
    survive_mask = sm;
    cmd_valid = 1'b1;
    if (cw) begin
      wr_en = 1'b1;
      wr_addr = A'(cw_addr);
      wr_data = cw_data;
    end
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    wr_en = 1'b0;
    birth_mask = ~bm;
    survive_mask = ~sm;
    cyc = 0;
    idle_seen = 0;
    rq.delete();
    while (cyc < 9 * N + 40) begin
      rb = 1'($urandom);
      rand_bit = rb;
      rq.push_back(rb);
      if (poke && cyc == 5) begin
        wr_en = 1'b1;
        wr_addr = A'(at(20, 12));
        wr_data = 1'b1;
      end else begin
        wr_en = 1'b0;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done1 || done0) break;
      if (!busy1 || ready1) idle_seen++;
    end
    cmd_valid = 1'b0;
    wr_en = 1'b0;
    check("done both instances", {done1, done0}, 2'b11);
    $display("cmd op=%0d cycles=%0d pop=%0d/%0d gen=%0d", op, cyc, pop1, pop0, gen1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, idle;
    logic [8:0] rbm, rsm;

    wv = '{'{3, 3, 1'b1, 1}, '{3, 3, 1'b1, 1}, '{3, 3, 1'b0, 0}, '{7, 2, 1'b1, 1},
           '{8, 2, 1'b1, 2}, '{7, 2, 1'b1, 2}, '{8, 2, 1'b0, 1}, '{7, 2, 1'b0, 0}};

    // Reset state
    #12;
    check("reset busy", busy1, 0);
    check("reset done", done1, 0);
    check("reset ready", ready1, 1);
    check("reset gen", gen1, 0);
    check("reset pop", pop1, 0);
    check("reset extinct", ext1, 1);
    check("reset changed", chg1, 0);
    check("reset rd_data", rd1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: CLEAR
    do_cmd(2'd1, 9'h0, 9'h0, 0, 0, 0, 0, 0, cyc, idle);
    model_fill(0);
    check("clear cycles", cyc, N + 1);
    check("clear busy during", idle, 0);
    check_stats("clear");
    @(negedge clk);
    check("done is one pulse", done1, 0);
    check_board("clear");

    // 2: blinker, B3/S23; second STEP pokes a write while busy (must be dropped)
    host_write(10, 5, 1);
    host_write(11, 5, 1);
    host_write(12, 5, 1);
    do_cmd(2'd0, 9'h008, 9'h00C, 0, 0, 0, 0, 0, cyc, idle);
    model_step(9'h008, 9'h00C);
    check("step1 cycles", cyc, 9 * N + 1);
    check("step1 pop", pop1, 3);
    check("step1 changed", chg1, 1);
    check_stats("step1");
    check_board("step1");
    do_cmd(2'd0, 9'h008, 9'h00C, 0, 1, 0, 0, 0, cyc, idle);
    model_step(9'h008, 9'h00C);
    check("step2 gen", gen1, 2);
    check_stats("step2");
    check_board("step2");

    // 3: row-0 blinker, third cell written on the accept edge
    do_cmd(2'd1, 9'h0, 9'h0, 0, 0, 0, 0, 0, cyc, idle);
    model_fill(0);
    host_write(0, 0, 1);
    host_write(1, 0, 1);
    mb[0][at(2, 0)] = 1'b1;
    mb[1][at(2, 0)] = 1'b1;
    do_cmd(2'd0, 9'h008, 9'h00C, 0, 0, 1, at(2, 0), 1, cyc, idle);
    model_step(9'h008, 9'h00C);
    check("edge pop wrap", pop1, 3);
    check("edge pop nowrap", pop0, 2);
    check_stats("edge");
    check_board("edge");

    // 4: still-life block with cmd_valid held through busy, then NOP
    do_cmd(2'd1, 9'h0, 9'h0, 0, 0, 0, 0, 0, cyc, idle);
    model_fill(0);
    host_write(4, 4, 1);
    host_write(5, 4, 1);
    host_write(4, 5, 1);
    host_write(5, 5, 1);
    do_cmd(2'd0, 9'h008, 9'h00C, 1, 0, 0, 0, 0, cyc, idle);
    model_step(9'h008, 9'h00C);
    check("block cycles", cyc, 9 * N + 1);
    check("block busy during", idle, 0);
    check("block changed", chg1, 0);
    check("block pop", pop1, 4);
    check_stats("block");
    @(negedge clk);
    check("no second cmd", busy1, 0);
    do_cmd(2'd3, 9'h1FF, 9'h1FF, 0, 0, 0, 0, 0, cyc, idle);
    check("nop cycles", cyc, 1);
    check_stats("nop");

    // 5: RANDOM then a rule that kills everything, then host-write vectors
    do_cmd(2'd2, 9'h0, 9'h0, 0, 0, 0, 0, 0, cyc, idle);
    model_fill(1);
    check("random cycles", cyc, N + 1);
    check_stats("random");
    check_board("random");
    do_cmd(2'd0, 9'h000, 9'h000, 0, 0, 0, 0, 0, cyc, idle);
    model_step(9'h000, 9'h000);
    check("kill pop", pop1, 0);
    check("kill extinct", ext1, 1);
    check_stats("kill");
    for (int i = 0; i < 8; i++) begin
      host_write(wv[i].x, wv[i].y, wv[i].d);
      check("wr pop wrap", pop1, wv[i].pop);
      check("wr pop nowrap", pop0, wv[i].pop);
      check("wr extinct", ext1, wv[i].pop == 0);
      $display("write (%0d,%0d)=%0d pop=%0d", wv[i].x, wv[i].y, wv[i].d, pop1);
    end

    // Random soup: Life, then a random rule
    do_cmd(2'd2, 9'h0, 9'h0, 0, 0, 0, 0, 0, cyc, idle);
    model_fill(1);
    check_stats("soup");
    do_cmd(2'd0, 9'h008, 9'h00C, 0, 0, 0, 0, 0, cyc, idle);
    model_step(9'h008, 9'h00C);
    check_stats("soup life");
    check_board("soup life");
    rbm = 9'($urandom);
    rsm = 9'($urandom);
    do_cmd(2'd0, rbm, rsm, 0, 0, 0, 0, 0, cyc, idle);
    model_step(rbm, rsm);
    check_stats("soup rule");
    check_board("soup rule");

    // 6: reset in the middle of a STEP
    @(negedge clk);
    cmd_op = 2'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2000) @(posedge clk);
    @(negedge clk);
    check("pre-reset busy", busy1, 1);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy1, 0);
    check("abort gen", gen1, 0);
    check("abort done", done1, 0);
    check("abort pop", pop1, 0);
    idle = 0;
    repeat (20) begin
      @(negedge clk);
      if (done1 || done0) idle++;
    end
    check("abort no done", idle, 0);
    rst_n = 1'b1;
    do_cmd(2'd1, 9'h0, 9'h0, 0, 0, 0, 0, 0, cyc, idle);
    model_fill(0);
    check("post-reset clear cycles", cyc, N + 1);
    check_stats("post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/life_engine_core.md
Name: life_engine_core

Overview:
Parametrised Game-of-Life compute core with a configurable board size, edge mode and Life-like rule.
- Holds two ping-pong cell banks and runs STEP, CLEAR and RANDOM commands over a valid/ready handshake.
- Exposes a registered read port for the UART display path and a single-cell write port for host editing.
- Keeps population, generation and activity status, so the terminal front-end can print stats without rescanning the board.

Parameters:
LOG_W, 5, log2 of board width (W = 2**LOG_W)
LOG_H, 4, log2 of board height (H = 2**LOG_H); N = W*H, A = LOG_W+LOG_H
WRAP, 1, 1 = toroidal edges; 0 = off-board neighbours count as dead
GEN_W, 16, generation counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high when IDLE
cmd_op  in  2  0=STEP, 1=CLEAR, 2=RANDOM, 3=NOP (accepted, done pulses next cycle, nothing changes)
birth_mask  in  9  bit n set: dead cell with n neighbours is born; sampled at accept
survive_mask  in  9  bit n set: live cell with n neighbours survives; sampled at accept
rand_bit  in  1  random source for RANDOM
wr_en  in  1  cell write; honoured only in IDLE
wr_addr  in  A  {y,x} of cell to write
wr_data  in  1  cell value
rd_addr  in  A  {y,x} of cell to read
rd_data  out  1  current-bank cell at rd_addr, registered, 1-cycle latency
busy  out  1  command executing
done  out  1  one-cycle pulse at command completion
gen_count  out  GEN_W  completed STEPs since last CLEAR/RANDOM
population  out  A+1  live cells in current bank
changed  out  1  last STEP altered at least one cell
extinct  out  1  population == 0

Behaviour:
- Reset (async, rst_n low) forces all registers immediately:
  - FSM to IDLE, bank select 0.
  - busy, done, changed, rd_data = 0; gen_count and population = 0; extinct = 1.
  - Cell arrays are not reset; their contents are unspecified until a CLEAR or RANDOM.
  - Reset mid-command aborts it; no done pulse is issued.
- Handshake:
  - cmd_ready = (state == IDLE).
  - Accept edge = cmd_valid && cmd_ready; masks are latched on that edge.
  - cmd_valid while busy is ignored.
- FSM: IDLE -> SCAN (STEP) | FILL (CLEAR/RANDOM) -> IDLE.
- STEP:
  - Cells are scanned x fastest, then y. Each cell takes 9 cycles: 8 neighbour reads from the current bank into a 4-bit count (0..8), then a commit cycle.
  - Commit writes the next bank with new = cur ? survive_mask[n] : birth_mask[n].
  - changed is set if any new != cur. population is recounted from the committed values.
  - After cell N-1, the bank select toggles (no copy pass) and gen_count increments (wraps at 2**GEN_W).
  - done pulses, and busy falls, exactly 9N+1 cycles after the accept edge.
- Edges:
  - WRAP=1: coordinate arithmetic is modulo W/H.
  - WRAP=0: a neighbour with x-1 < 0, x+1 >= W, y-1 < 0 or y+1 >= H contributes 0.
- CLEAR writes 0 to every current-bank cell; RANDOM writes rand_bit, sampled each cycle.
  - Each is N write cycles. done pulses N+1 cycles after accept.
  - gen_count := 0, changed := 0, population := number of 1s written.
- During STEP the current bank is untouched, so the display reads a stable frame. During FILL, rd_data may show partial content.
- wr_en in IDLE:
  - Writes the current bank on that edge.
  - population is updated incrementally: +1 when a 0 is overwritten by 1, -1 when a 1 is overwritten by 0, unchanged otherwise.
  - If wr_en and a command accept coincide, the write commits first and the command's first cell access is next cycle.
  - wr_en outside IDLE is dropped.
- extinct is combinational from population.

Test Plan:
1. Reset, CLEAR (W=32, H=16) -> done exactly 513 cycles after accept; population=0, extinct=1, gen_count=0; all 512 reads return 0.
2. WRAP=1, B3/S23 (birth=9'h008, survive=9'h00C); write (10,5),(11,5),(12,5); STEP -> done at 4609 cycles; live cells (11,4),(11,5),(11,6) only; population=3, gen_count=1, changed=1. Second STEP -> horizontal blinker again, gen_count=2.
3. Row-0 blinker (0,0),(1,0),(2,0): WRAP=1 STEP -> live (1,15),(1,0),(1,1), population 3. WRAP=0 STEP -> live (1,0),(1,1) only, population 2.
4. 2x2 block at (4,4), STEP -> changed=0, population=4, gen_count increments. cmd_valid held during busy -> no second command starts before done.
5. birth_mask=0, survive_mask=0 after RANDOM -> one STEP gives population=0, extinct=1. Write 1 at (3,3) -> population=1; write 1 again -> still 1; write 0 -> 0.
6. Assert rst_n=0 mid-STEP (cycle 2000) -> busy=0 and gen_count=0 immediately, no done pulse; a following CLEAR completes normally.
